// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and type.
package bit_serial_adder_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/bit_serial_adder_full_adder.sv
// Single-bit full-adder cell; the only arithmetic in the bit-serial adder.
module bit_serial_adder_full_adder (
    input  logic i_BIT_ONE,
    input  logic i_BIT_TWO,
    input  logic i_BIT_IN,
    output logic o_BIT_SUM,
    output logic o_BIT_CARRY
);

    logic half_sum;

    // Sum and carry of three input bits.
    always_comb begin
        half_sum    = i_BIT_ONE ^ i_BIT_TWO;
        o_BIT_SUM   = half_sum ^ i_BIT_IN;
        o_BIT_CARRY = (i_BIT_ONE & i_BIT_TWO) | (i_BIT_IN & half_sum);
    end

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB first, one bit per clock,
// through a single time-shared full-adder cell with a registered carry.
// Optional signed-overflow output enabled by defining BIT_SERIAL_ADDER_OVERFLOW_EN.
//
// Handshake: i_START is taken whenever o_BUSY is low (IDLE or DONE). The
// accepting edge loads the operands; o_BUSY is then high for WIDTH cycles,
// and o_DONE pulses for exactly one cycle while a new o_SUM/o_CARRY_OUT is
// first visible. Results hold until the next accepted operation completes.
// i_START while o_BUSY is high is ignored.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_START,
    input  logic [WIDTH-1:0] i_OPERAND_A,
    input  logic [WIDTH-1:0] i_OPERAND_B,
    input  logic             i_CARRY_IN,
    output logic             o_BUSY,
    output logic             o_DONE,
    output logic [WIDTH-1:0] o_SUM,
    output logic             o_CARRY_OUT,
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
    output logic             o_OVERFLOW,
`endif
    output state_t           o_STATE
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
    logic             ovf_q;
`endif

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] sum_d;

    bit_serial_adder_full_adder Full_Adder (
        .i_BIT_ONE   (a_q[0]),
        .i_BIT_TWO   (b_q[0]),
        .i_BIT_IN    (carry_q),
        .o_BIT_SUM   (fa_sum),
        .o_BIT_CARRY (fa_carry)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is at the LSB.
    always_comb begin
        sum_d = {fa_sum, sum_q[WIDTH-1:1]};
    end

    // FSM, operand/sum shift registers, bit counter and registered outputs.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (i_START) begin
                        a_q     <= i_OPERAND_A;
                        b_q     <= i_OPERAND_B;
                        carry_q <= i_CARRY_IN;
                        sum_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    sum_q   <= sum_d;
                    carry_q <= fa_carry;
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    if (cnt_q == LAST_BIT) begin
                        // Last bit: publish the result; the counter stays put so it never wraps.
                        result_q <= sum_d;
                        cout_q   <= fa_carry;
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
                        ovf_q    <= carry_q ^ fa_carry;
`endif
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_BUSY      = busy_q;
    assign o_DONE      = done_q;
    assign o_SUM       = result_q;
    assign o_CARRY_OUT = cout_q;
`ifdef BIT_SERIAL_ADDER_OVERFLOW_EN
    assign o_OVERFLOW  = ovf_q;
`endif
    assign o_STATE     = state_q;

endmodule

// File: doc/bit_serial_adder.md
# bit_serial_adder

Bit-serial adder that adds two WIDTH-bit operands one bit per clock. It loads both operands and a carry-in into shift registers, and streams one LSB-first bit pair per cycle through a single Full_Adder cell. A registered carry closes the loop between bits. It serves area-constrained datapaths where one adder cell is time-shared instead of instantiating a WIDTH-bit ripple adder.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits; legal range WIDTH >= 2.

Ports:
- i_CLK, input, 1, sole clock; all state is updated on the rising edge.
- i_RST, input, 1, asynchronous active-high reset.
- i_START, input, 1, start request; sampled only when o_BUSY = 0.
- i_OPERAND_A, input, WIDTH, first addend; captured on an accepted start.
- i_OPERAND_B, input, WIDTH, second addend; captured on an accepted start.
- i_CARRY_IN, input, 1, carry into bit 0; captured on an accepted start.
- o_BUSY, output, 1, high while bits are being added.
- o_DONE, output, 1, one-cycle pulse; high while o_SUM and o_CARRY_OUT are first valid.
- o_SUM, output, WIDTH, result; held until the next accepted start completes.
- o_CARRY_OUT, output, 1, carry out of bit WIDTH-1; held like o_SUM.
- o_OVERFLOW, output, 1, signed overflow; present only with the macro defined (see Configuration).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - i_START = 1 loads the A/B shift registers and the carry register (= i_CARRY_IN).
  - Clears the bit counter and the sum shift register.
  - Next state is SHIFT.
- SHIFT:
  - Each cycle, A[0], B[0] and the carry register feed the Full_Adder.
  - The sum bit shifts into the MSB of the sum register (right shift).
  - The carry register takes the adder carry-out.
  - A and B shift right by one; the counter increments.
  - When the counter reaches WIDTH-1 (the last bit is processed on this edge), the next state is DONE.
- DONE:
  - o_DONE = 1.
  - The sum shift register drives o_SUM and the carry register drives o_CARRY_OUT.
  - i_START = 1 in DONE is accepted exactly as in IDLE, so back-to-back operation is supported; otherwise the next state is IDLE.
- Arithmetic: {o_CARRY_OUT, o_SUM} = A + B + i_CARRY_IN, modulo 2^(WIDTH+1), unsigned.
- The counter is $clog2(WIDTH) bits wide and never wraps within an operation.
- i_START while o_BUSY = 1 is ignored; in-flight operands are unaffected.
- Operand inputs are don't-care except on the cycle a start is accepted.

## Timing
- Reset: all of the following clear to 0 and the state goes to IDLE, immediately and asynchronously:
  - o_BUSY, o_DONE, o_SUM, o_CARRY_OUT, o_OVERFLOW;
  - the counter and all shift and carry registers.
- Reset mid-operation aborts the operation; no o_DONE pulse is issued and no partial result appears.
- Start accepted at edge E0. o_BUSY is high from after E0 through edge E(WIDTH).
- o_DONE is high for the one cycle following edge E(WIDTH); result latency is WIDTH+1 edges.
- Minimum start-to-start interval is WIDTH+1 cycles (start issued during DONE).
- o_SUM/o_CARRY_OUT change only on the edge entering DONE; they are stable in IDLE.

## Configuration
- Macro: BIT_SERIAL_ADDER_OVERFLOW_EN.
- Defined:
  - The o_OVERFLOW port exists.
  - During the final SHIFT cycle, the carry into bit WIDTH-1 (the carry register value before the update) is XORed with the carry out.
  - The result is registered and presented with o_SUM, held until the next result, and cleared on reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package bit_serial_adder_pkg holds the state typedef (IDLE, SHIFT, DONE) and the state encoding constants.
- Sub-module: one Full_Adder instance, the only arithmetic in the block. Its ports map as:
  - A[0] -> i_BIT_ONE;
  - B[0] -> i_BIT_TWO;
  - carry register -> i_BIT_IN;
  - o_BIT_SUM -> sum register MSB;
  - o_BIT_CARRY -> carry register next value.
- FSM, counter and shift registers stay inline in bit_serial_adder.

## Test plan
- WIDTH=8, A=0x5A, B=0x3C, cin=0, start at E0 -> o_DONE high after E8 only, o_SUM=0x96, o_CARRY_OUT=0, o_BUSY high exactly 8 cycles.
- A=0xFF, B=0x01, cin=0 -> o_SUM=0x00, o_CARRY_OUT=1; then A=0xFF, B=0xFF, cin=1 started during DONE -> o_SUM=0xFF, o_CARRY_OUT=1, no idle gap.
- OVERFLOW_EN defined:
  - A=0x7F, B=0x01 -> o_SUM=0x80, o_OVERFLOW=1;
  - A=0x80, B=0x80 -> o_SUM=0x00, o_CARRY_OUT=1, o_OVERFLOW=1;
  - A=0x10, B=0x20 -> o_OVERFLOW=0.
- Start A=0x01, B=0x01, then i_START with A=0xAA, B=0x55 on cycle 3 while busy -> ignored, o_SUM=0x02, single o_DONE.
- Assert i_RST asynchronously at cycle 4 of an operation -> all outputs 0 at once, no o_DONE, state IDLE; a fresh start then completes correctly.
- Random sweep, 1000 operations with WIDTH=8 and WIDTH=13 -> {o_CARRY_OUT, o_SUM} matches A+B+cin every time.
